// File: rtl/dual_scaler_readout.sv
// dual_scaler_readout: issues update pulses to a bank of dual scalers,
// collects their 48-bit returns as 24-bit channels with saturation flags,
// commits them atomically and serves them on a 1-cycle-latency read port.
module dual_scaler_readout #(
   parameter int NUM_PAIRS      = 4,
   parameter int PERIOD_CLOCKS  = 1000000,
   parameter int TIMEOUT_CLOCKS = 32,
   parameter int ADDR_BITS      = 3
) (
   input  logic                    fast_clk_i,
   input  logic                    fast_rst_n_i,
   input  logic                    enable_i,
   input  logic                    manual_req_i,
   output logic                    update_o,
   input  logic [48*NUM_PAIRS-1:0] scaler_value_i,
   input  logic [NUM_PAIRS-1:0]    scaler_valid_i,
   input  logic [ADDR_BITS-1:0]    rd_addr_i,
   output logic [24:0]             rd_data_o,
   output logic                    new_data_o,
   output logic [15:0]             seq_o,
   output logic                    timeout_o,
   output logic                    overrun_o,
   input  logic                    clear_flags_i
);

   localparam int CH = 2 * NUM_PAIRS;
   localparam int PW = $clog2(PERIOD_CLOCKS);
   localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [PW-1:0]            per_q;
   logic                     tick;
   logic [1:0]               state_q, state_d;
   logic [NUM_PAIRS-1:0]     got_q, got_d;
   logic [TW-1:0]            tcnt_q, tcnt_d;
   logic [CH-1:0][24:0]      shadow_q, shadow_d;
   logic [CH-1:0][24:0]      bank_q, bank_d;
   logic                     update_q, update_d;
   logic                     new_q, new_d;
   logic [15:0]              seq_q, seq_d;
   logic                     timeout_q, timeout_d;
   logic                     overrun_q, overrun_d;
   logic                     to_set;
   logic [24:0]              rd_q, rd_d;

   // the tick fires on the enabled cycle in which the counter sits at zero
   assign tick = enable_i && (per_q == '0);

   // free-running period counter; holds its value while disabled
   always_ff @(posedge fast_clk_i) begin
      if (!fast_rst_n_i)   per_q <= PW'(PERIOD_CLOCKS - 1);
      else if (enable_i)   per_q <= (per_q == '0) ? PW'(PERIOD_CLOCKS - 1) : per_q - 1'b1;
   end

   // capture FSM next state: request, collect valids, commit
   always_comb begin
      state_d  = state_q;
      got_d    = got_q;
      tcnt_d   = tcnt_q;
      shadow_d = shadow_q;
      bank_d   = bank_q;
      seq_d    = seq_q;
      update_d = 1'b0;
      to_set   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick || manual_req_i) begin
               update_d = 1'b1;
               state_d  = S_WAIT;
               got_d    = '0;
               tcnt_d   = '0;
            end
         end
         S_WAIT: begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
               if (scaler_valid_i[k]) begin
                  got_d[k] = 1'b1;
                  shadow_d[2*k]   = {(scaler_value_i[48*k +: 24] == 24'hFFFFFF),
                                     scaler_value_i[48*k +: 24]};
                  shadow_d[2*k+1] = {(scaler_value_i[48*k+24 +: 24] == 24'hFFFFFF),
                                     scaler_value_i[48*k+24 +: 24]};
               end
            end
            if (&got_d) begin
               state_d = S_COMMIT;
            end else if (tcnt_q == TW'(TIMEOUT_CLOCKS - 1)) begin
               state_d = S_COMMIT;
               to_set  = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_COMMIT: begin
            // pairs that never answered keep their previous bank contents
            for (int k = 0; k < NUM_PAIRS; k++) begin
               if (got_q[k]) begin
                  bank_d[2*k]   = shadow_q[2*k];
                  bank_d[2*k+1] = shadow_q[2*k+1];
               end
            end
            seq_d   = seq_q + 16'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // sticky flags: a set in the same cycle as a clear leaves the flag set
   always_comb begin
      new_d     = (state_q == S_COMMIT);
      timeout_d = to_set ? 1'b1 : (clear_flags_i ? 1'b0 : timeout_q);
      overrun_d = (tick && state_q != S_IDLE) ? 1'b1 :
                  (clear_flags_i ? 1'b0 : overrun_q);
   end

   // read mux; unmapped addresses return zero
   always_comb begin
      rd_d = '0;
      for (int c = 0; c < CH; c++) begin
         if (rd_addr_i == ADDR_BITS'(c)) rd_d = bank_q[c];
      end
   end

   // state registers; reset abandons any capture in flight
   always_ff @(posedge fast_clk_i) begin
      if (!fast_rst_n_i) begin
         state_q   <= S_IDLE;
         got_q     <= '0;
         tcnt_q    <= '0;
         shadow_q  <= '0;
         bank_q    <= '0;
         update_q  <= 1'b0;
         new_q     <= 1'b0;
         seq_q     <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         got_q     <= got_d;
         tcnt_q    <= tcnt_d;
         shadow_q  <= shadow_d;
         bank_q    <= bank_d;
         update_q  <= update_d;
         new_q     <= new_d;
         seq_q     <= seq_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
         rd_q      <= rd_d;
      end
   end

   assign update_o   = update_q;
   assign new_data_o = new_q;
   assign seq_o      = seq_q;
   assign timeout_o  = timeout_q;
   assign overrun_o  = overrun_q;
   assign rd_data_o  = rd_q;

endmodule

// File: tb/tb_dual_scaler_readout.sv
// Directed bench for dual_scaler_readout: a scaler model answers update
// pulses, a channel model predicts the bank, reads go through a queue.
module tb_dual_scaler_readout;
   localparam int NP  = 4;
   localparam int PER = 64;
   localparam int TO  = 32;
   localparam int AB  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              manual = 1'b0;
   logic              clear = 1'b0;
   logic [48*NP-1:0]  sval = '0;
   logic [NP-1:0]     svld = '0;
   logic [AB-1:0]     rd_addr = '0;
   logic              update_o, new_data_o, timeout_o, overrun_o;
   logic [24:0]       rd_data_o;
   logic [15:0]       seq_o;

   dual_scaler_readout #(
      .NUM_PAIRS(NP), .PERIOD_CLOCKS(PER), .TIMEOUT_CLOCKS(TO), .ADDR_BITS(AB)
   ) dut (
      .fast_clk_i(clk), .fast_rst_n_i(rst_n), .enable_i(enable),
      .manual_req_i(manual), .update_o(update_o), .scaler_value_i(sval),
      .scaler_valid_i(svld), .rd_addr_i(rd_addr), .rd_data_o(rd_data_o),
      .new_data_o(new_data_o), .seq_o(seq_o), .timeout_o(timeout_o),
      .overrun_o(overrun_o), .clear_flags_i(clear)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          upd_cnt = 0;
   int          nd_cnt = 0;
   logic [24:0] exp_ch [2*NP];
   logic [15:0] exp_seq = '0;
   logic [24:0] rdq [$];

   always @(negedge clk) begin
      if (update_o)   upd_cnt++;
      if (new_data_o) nd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic rd(input int a);
      logic [24:0] e;
      rd_addr = AB'(a);
      rdq.push_back((a < 2*NP) ? exp_ch[a] : 25'd0);
      @(negedge clk);
      e = rdq.pop_front();
      chk($sformatf("rd ch%0d", a), 32'(rd_data_o), 32'(e));
   endtask

   task automatic pulse_manual();
      manual = 1'b1;
      @(negedge clk);
      manual = 1'b0;
   endtask

   // scaler model: answers 10 clocks after update_o with the masked pairs
   task automatic capture(input logic [NP-1:0] mask, input logic [48*NP-1:0] vals,
                          output int lat, output logic [24:0] rd_at_nd);
      logic [23:0] lo, hi;
      lat = -1;
      rd_at_nd = '0;
      for (int i = 0; i < 200 && !update_o; i++) @(negedge clk);
      if (!update_o) begin
         chk("update_o seen", 32'(update_o), 32'd1);
         return;
      end
      sval = vals;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (new_data_o) begin
            lat = c;
            rd_at_nd = rd_data_o;
            break;
         end
         svld = (c == 10) ? mask : '0;
      end
      svld = '0;
      if (lat < 0) begin
         chk("new_data_o seen", 32'(new_data_o), 32'd1);
         return;
      end
      exp_seq = exp_seq + 16'd1;
      for (int k = 0; k < NP; k++) begin
         if (mask[k]) begin
            lo = vals[48*k +: 24];
            hi = vals[48*k+24 +: 24];
            exp_ch[2*k]   = {(lo == 24'hFFFFFF), lo};
            exp_ch[2*k+1] = {(hi == 24'hFFFFFF), hi};
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
      $fatal(1);
   end

   initial begin
      logic [48*NP-1:0] v;
      logic [24:0]      rnd;
      int               lat, u0, n0;
      for (int i = 0; i < 2*NP; i++) exp_ch[i] = '0;

      // reset
      repeat (3) @(negedge clk);
      chk("rst update_o", 32'(update_o), 32'd0);
      chk("rst new_data_o", 32'(new_data_o), 32'd0);
      chk("rst seq_o", 32'(seq_o), 32'd0);
      chk("rst timeout_o", 32'(timeout_o), 32'd0);
      chk("rst overrun_o", 32'(overrun_o), 32'd0);
      chk("rst rd_data_o", 32'(rd_data_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // full manual capture
      for (int k = 0; k < NP; k++) v[48*k +: 48] = {24'(k + 'h100), 24'(k)};
      u0 = upd_cnt; n0 = nd_cnt;
      pulse_manual();
      capture(4'hF, v, lat, rnd);
      chk("full latency", 32'(lat), 32'd12);
      repeat (4) @(negedge clk);
      chk("t1 updates", 32'(upd_cnt - u0), 32'd1);
      chk("t1 new_data", 32'(nd_cnt - n0), 32'd1);
      chk("t1 seq", 32'(seq_o), 32'(exp_seq));
      for (int a = 0; a <= 2*NP; a++) rd(a);

      // saturation on pair 2 high half
      v[2*48 +: 48] = {24'hFFFFFF, 24'h000005};
      pulse_manual();
      capture(4'hF, v, lat, rnd);
      @(negedge clk);
      chk("t2 seq", 32'(seq_o), 32'(exp_seq));
      rd(4);
      rd(5);

      // pair 3 silent: timeout, ch6/ch7 keep the old bank value
      for (int k = 0; k < NP; k++) v[48*k +: 48] = {24'(k + 'h200), 24'(k + 'h20)};
      v[3*48 +: 48] = {24'h000ABC, 24'h000DEF};
      pulse_manual();
      capture(4'h7, v, lat, rnd);
      chk("timeout latency", 32'(lat), 32'(TO + 1));
      @(negedge clk);
      chk("t3 timeout_o", 32'(timeout_o), 32'd1);
      chk("t3 seq", 32'(seq_o), 32'(exp_seq));
      chk("t3 overrun_o", 32'(overrun_o), 32'd0);
      rd(6);
      rd(7);
      rd(0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("t3 cleared timeout_o", 32'(timeout_o), 32'd0);

      // periodic tick lands inside a long capture
      u0 = upd_cnt;
      enable = 1'b1;
      repeat (40) @(negedge clk);
      pulse_manual();
      capture(4'h0, v, lat, rnd);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4 overrun_o", 32'(overrun_o), 32'd1);
      chk("t4 timeout_o", 32'(timeout_o), 32'd1);
      chk("t4 updates", 32'(upd_cnt - u0), 32'd1);
      chk("t4 seq", 32'(seq_o), 32'(exp_seq));
      rd(2);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("t4 cleared overrun_o", 32'(overrun_o), 32'd0);

      // reset in the middle of a capture
      u0 = upd_cnt; n0 = nd_cnt;
      pulse_manual();
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2*NP; i++) exp_ch[i] = '0;
      exp_seq = '0;
      sval = v;
      svld = 4'hF;
      @(negedge clk);
      svld = '0;
      repeat (40) @(negedge clk);
      chk("t5 new_data", 32'(nd_cnt - n0), 32'd0);
      chk("t5 updates", 32'(upd_cnt - u0), 32'd1);
      chk("t5 seq", 32'(seq_o), 32'd0);
      chk("t5 timeout_o", 32'(timeout_o), 32'd0);
      for (int a = 0; a < 2*NP; a++) rd(a);

      // read in the commit cycle sees the pre-commit value
      for (int k = 0; k < NP; k++) v[48*k +: 48] = {24'(k + 'h300), 24'(k + 'h30)};
      v[23:0] = 24'h000010;
      pulse_manual();
      capture(4'hF, v, lat, rnd);
      rd_addr = '0;
      rdq.push_back(exp_ch[0]);
      v[23:0] = 24'h000020;
      pulse_manual();
      capture(4'hF, v, lat, rnd);
      chk("commit-cycle read", 32'(rnd), 32'(rdq.pop_front()));
      rd(0);
      rd(1);
      chk("t6 seq", 32'(seq_o), 32'(exp_seq));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dual_scaler_readout.md
Name: dual_scaler_readout

Overview:
- Reader end of the dual prescaled DSP scaler interface: issues update pulses to a bank of NUM_PAIRS dual scalers and collects each scaler's 48-bit value/valid return.
- Splits each 48-bit word into two 24-bit channels and detects saturation (0xFFFFFF).
- Commits all channels atomically into a readable bank, then exposes them through a 1-cycle-latency random-read port.
- Sits in the fast clock domain beside the scaler bank; feeds the register/readout path.

Parameters:
- NUM_PAIRS, 4, number of dual scalers served; channels = 2*NUM_PAIRS.
- PERIOD_CLOCKS, 1000000, clocks between automatic update pulses; minimum 64.
- TIMEOUT_CLOCKS, 32, clocks to wait for all valids after update; must be < PERIOD_CLOCKS.
- ADDR_BITS, 3, read address width; 2^ADDR_BITS >= 2*NUM_PAIRS.

Ports:
- fast_clk_i  in  1  clock.
- fast_rst_n_i  in  1  synchronous active-low reset.
- enable_i  in  1  enables periodic updates; manual requests work regardless.
- manual_req_i  in  1  single-cycle request for an immediate update.
- update_o  out  1  single-cycle update pulse, fanned to all scalers.
- scaler_value_i  in  48*NUM_PAIRS  pair k occupies [48k+47:48k].
- scaler_valid_i  in  NUM_PAIRS  per-pair valid pulses.
- rd_addr_i  in  ADDR_BITS  channel index.
- rd_data_o  out  25  {sat, count[23:0]}.
- new_data_o  out  1  single-cycle pulse on commit.
- seq_o  out  16  commit sequence number.
- timeout_o  out  1  sticky: last cycle ended in timeout.
- overrun_o  out  1  sticky: a periodic tick was dropped.
- clear_flags_i  in  1  clears timeout_o and overrun_o.

Behaviour:
- Reset (fast_rst_n_i=0 at a clock edge) sets:
  - all outputs to 0; bank and shadow registers to 0;
  - FSM to IDLE;
  - period counter to PERIOD_CLOCKS-1.
- Reset mid-capture abandons the capture with no commit. Valids that arrive after reset are ignored in IDLE.
- Period counter:
  - Decrements each clock while enable_i=1.
  - At 0 it raises an internal tick and reloads PERIOD_CLOCKS-1.
  - enable_i=0 holds the counter. Re-enabling resumes from the held value.
- FSM: IDLE, WAIT_VALID, COMMIT.
- IDLE:
  - A tick or manual_req_i causes update_o=1 on the next cycle and a transition to WAIT_VALID.
  - On entry to WAIT_VALID, the got-mask and timeout counter are cleared.
  - A tick and manual_req_i together produce one update.
- WAIT_VALID:
  - scaler_valid_i[k]=1 captures pair k into shadow and sets got[k].
  - A repeated valid for the same pair overwrites the shadow (last wins).
  - got all ones moves to COMMIT.
  - Otherwise the timeout counter increments; at TIMEOUT_CLOCKS the FSM moves to COMMIT with timeout_o set.
  - Pairs not received hold their previous bank values, not the shadow values.
- COMMIT (1 cycle):
  - The bank takes the shadow for received pairs.
  - seq_o increments, wrapping 0xFFFF to 0.
  - new_data_o pulses on the following cycle.
  - Then return to IDLE.
- Busy handling: a tick while not IDLE is dropped and sets overrun_o; the period counter keeps running. manual_req_i while not IDLE is ignored with no flag.
- Channel mapping:
  - channel 2k = pair k bits [23:0];
  - channel 2k+1 = pair k bits [47:24].
- sat = (count == 24'hFFFFFF), computed at capture.
- Read port:
  - rd_data_o is registered from rd_addr_i with 1-cycle latency.
  - Address >= 2*NUM_PAIRS returns 0.
  - A read in the COMMIT cycle returns the pre-commit value.
- clear_flags_i clears the sticky flags. Setting a flag in the same cycle as a clear wins (flag ends set).
- The nominal scaler return is 10 clocks after update_o, so the default timeout leaves margin.

Test Plan:
- Reset, NUM_PAIRS=4, enable_i=0, manual_req_i pulse, all pairs return valid 10 clocks after update_o with pair k = {24'(k+0x100), 24'(k)} -> one update_o, new_data_o once, seq_o=1; rd_addr 0..7 reads in order 0x000000, 0x000100, 0x000001, 0x000101, 0x000002, 0x000102, 0x000003, 0x000103 (one value per address), sat=0, rd_addr=8 reads 0.
- Pair 2 returns {24'hFFFFFF, 24'h000005} -> ch5 = {1, FFFFFF}, ch4 = {0, 000005}.
- Pair 3 never returns valid; earlier bank ch6 = 0x000003 -> commit after TIMEOUT_CLOCKS, timeout_o=1, ch6 still 0x000003, seq increments; clear_flags_i clears timeout_o.
- PERIOD_CLOCKS=64, enable_i=1, TIMEOUT forced long via missing valid -> tick arrives while in WAIT_VALID, overrun_o=1, no second update_o during the capture.
- Reset asserted 5 clocks into WAIT_VALID, then valids arrive -> no commit, seq_o=0, bank all 0.
- Read ch0 in the COMMIT cycle, old=0x000010, new=0x000020 -> returns 0x000010; next read returns 0x000020.
